gearbox_upsizing_nx: RTL and testbench
======================================

Name: gearbox_upsizing_nx

Overview:
- Parametrised successor of the fixed 2x AXI-Stream upsizer.
- Packs RATIO consecutive N_BYTES-wide input beats into one RATIO*N_BYTES-wide output beat.
- Adds tlast support: a packet end flushes a partial output word, with byte-granular tkeep marking valid bytes.
- Sits between narrow producers (e.g. byte-packed parsers) and wide datapath stages.

Parameters:
- N_BYTES, 5, bytes per input beat (input width NB = N_BYTES*8).
- RATIO, 2, input beats per output beat; legal range 2..16.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous and active-low.
- in_tdata  in  NB  input beat data.
- in_tvalid  in  1  input valid.
- in_tlast  in  1  last beat of the packet.
- in_tready  out  1  input ready.
- out_tdata  out  NB*RATIO  packed output data.
- out_tkeep  out  N_BYTES*RATIO  byte-valid mask.
- out_tlast  out  1  packet end.
- out_tvalid  out  1  output valid.
- out_tready  in  1  output ready.

Behaviour:
- Reset (aresetn low, asynchronous): out_tvalid=0, out_tlast=0, out_tdata=0, out_tkeep=0, lane counter=0, accumulator=0. in_tready is forced to 0 while aresetn is low.
- Reset mid-packet: the partial accumulator is discarded and no output is emitted for it.
- Input handshake: a beat is accepted when in_tvalid & in_tready. in_tready = !out_tvalid | out_tready, which is registered-state based and does not depend on in_tvalid.
- Lane order: lane counter cnt (0..RATIO-1) selects the destination slice. Beat k of a group goes to bits [k*NB +: NB], so the first beat lands in the LSBs.
- Emit condition: on acceptance with cnt==RATIO-1 or in_tlast==1, the output register loads on the same edge:
  - out_tdata = accumulator with the current beat merged; unfilled lanes are 0.
  - out_tkeep = ones for bytes 0..(cnt+1)*N_BYTES-1, zeros above.
  - out_tlast = in_tlast.
  - out_tvalid = 1, and cnt returns to 0.
- Otherwise, on acceptance the beat is written to its lane and cnt increments.
- Latency: out_tvalid rises on the edge that accepts the completing beat, so the output is visible the following cycle.
- Throughput: with out_tready=1, one input beat is accepted per cycle indefinitely with no bubbles.
- Output handshake: out_tvalid clears on out_tvalid & out_tready unless a new emit occurs on the same edge; in that case the output is reloaded and out_tvalid stays 1.
- Stability: while out_tvalid & !out_tready, out_tdata, out_tkeep and out_tlast are held stable and in_tready=0.
- in_tlast when cnt==RATIO-1 produces a full word (tkeep all ones) with out_tlast=1.
- in_tlast on the first beat produces a single-lane word with tkeep = N_BYTES ones.
- Beats with in_tvalid=0 leave the accumulator and cnt unchanged, so pauses of any length are allowed mid-group.

Decomposition:
- Package gearbox_pkg holds:
  - localparam helpers for NB and OUT_W;
  - function keep_mask(lanes) returning N_BYTES*RATIO bits;
  - the lane counter width $clog2(RATIO).
- One sub-module, axis_out_reg: an output register slice holding data, keep, last and valid with the load/hold/clear rules above. The top level contains the accumulator and lane counter.

Test Plan:
- N_BYTES=5, RATIO=2, out_tready=1; send "ABCDE","FGHIJ" back-to-back, no tlast -> one beat with out_tdata=0x464748494A_4142434445, out_tkeep=0x3FF, out_tlast=0; in_tready stays 1.
- Same config; "ABCDE" then a 16-cycle pause then "FGHIJ" -> identical single output beat, no spurious out_tvalid during the pause.
- RATIO=4; send 3 beats "AAAAA","BBBBB","CCCCC" with tlast on the 3rd -> out_tdata upper lane 0, lower 15 bytes = 0x4343434343_4242424242_4141414141, out_tkeep=0x07FFF, out_tlast=1; next packet starts at lane 0.
- RATIO=2; hold out_tready=0 for 10 cycles after the first emit -> in_tready=0 and out_* stable throughout; on release, the second group follows with no lost or duplicated beats (scoreboard-checked).
- RATIO=2; random in_tvalid/out_tready at 50% over 1000 beats with random tlast -> the scoreboard matches all data and keep values; the error count is 0.
- Assert aresetn low after one beat of a group, then release -> outputs 0 during reset; the next two beats form a fresh output word with no trace of the discarded beat.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared sizing helpers and the byte-valid mask builder for the N:1 AXI-Stream upsizer.
package gearbox_pkg;

    localparam int unsigned N_BYTES_DEF = 5;
    localparam int unsigned RATIO_DEF   = 2;
    localparam int unsigned MAX_KEEP_W  = 1024;

    function automatic int unsigned data_w(input int unsigned n_bytes);
        return n_bytes * 8;
    endfunction

    function automatic int unsigned out_w(input int unsigned n_bytes, input int unsigned ratio);
        return n_bytes * 8 * ratio;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

    // Ones for the low lanes*n_bytes bytes; callers truncate to their own keep width.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned lanes,
                                                        input int unsigned n_bytes);
        return ~({MAX_KEEP_W{1'b1}} << (lanes * n_bytes));
    endfunction

endpackage

// File: rtl/gearbox_upsizing_nx_axis_out_reg.sv
// Output register slice: loads a packed word, holds it under backpressure, clears on handshake.
module axis_out_reg #(
    parameter int unsigned DATA_W = 80,
    parameter int unsigned KEEP_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic [KEEP_W-1:0] keep_in,
    input  logic              last_in,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] keep,
    output logic              last,
    output logic              valid
);

    // A load on the same edge as a consumed beat wins, keeping valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            keep  <= keep_in;
            last  <= last_in;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gearbox_upsizing_nx.sv
// Packs RATIO narrow AXI-Stream beats into one wide beat; tlast flushes a partial word.
module gearbox_upsizing_nx
    import gearbox_pkg::*;
#(
    parameter int unsigned N_BYTES = N_BYTES_DEF,
    parameter int unsigned RATIO   = RATIO_DEF
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_BYTES*8-1:0]         in_tdata,
    input  logic                         in_tvalid,
    input  logic                         in_tlast,
    output logic                         in_tready,
    output logic [N_BYTES*8*RATIO-1:0]   out_tdata,
    output logic [N_BYTES*RATIO-1:0]     out_tkeep,
    output logic                         out_tlast,
    output logic                         out_tvalid,
    input  logic                         out_tready
);

    localparam int unsigned NB        = data_w(N_BYTES);
    localparam int unsigned OUT_W     = out_w(N_BYTES, RATIO);
    localparam int unsigned KEEP_W    = N_BYTES * RATIO;
    localparam int unsigned CNT_W     = cnt_w(RATIO);
    localparam int unsigned LAST_LANE = RATIO - 1;

    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  merged;
    logic [CNT_W-1:0]  cnt;
    logic [KEEP_W-1:0] keep_c;
    logic              accept;
    logic              last_lane;
    logic              emit;

    // Ready depends only on the output register, never on in_tvalid.
    assign in_tready = aresetn & (~out_tvalid | out_tready);
    assign accept    = in_tvalid & in_tready;
    assign last_lane = (cnt == CNT_W'(LAST_LANE));
    assign emit      = accept & (last_lane | in_tlast);
    assign keep_c    = KEEP_W'(keep_mask(32'(cnt) + 32'd1, N_BYTES));

    // Current beat merged into its lane; lanes above cnt are still zero.
    always_comb begin
        merged = acc;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt == CNT_W'(k)) begin
                merged[k*NB +: NB] = in_tdata;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc <= '0;
            cnt <= '0;
        end else if (emit) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= merged;
            cnt <= cnt + CNT_W'(1);
        end
    end

    axis_out_reg #(
        .DATA_W (OUT_W),
        .KEEP_W (KEEP_W)
    ) u_out_reg (
        .clk     (aclk),
        .rst_n   (aresetn),
        .load    (emit),
        .data_in (merged),
        .keep_in (keep_c),
        .last_in (in_tlast),
        .ready   (out_tready),
        .data    (out_tdata),
        .keep    (out_tkeep),
        .last    (out_tlast),
        .valid   (out_tvalid)
    );

endmodule

// File: tb/tb_gearbox_upsizing_nx.sv
// Scoreboard bench for the N:1 upsizer: RATIO=2 random/directed traffic plus a RATIO=4 flush case.
module tb_gearbox_upsizing_nx;

    typedef struct {
        logic [79:0] data;
        logic [9:0]  keep;
        logic        last;
    } exp_t;

    typedef struct {
        logic [159:0] data;
        logic [19:0]  keep;
        logic         last;
    } got4_t;

    logic         aclk;
    logic         aresetn;
    logic [39:0]  in_tdata;
    logic         in_tvalid;
    logic         in_tlast;
    logic         in_tready;
    logic [79:0]  out_tdata;
    logic [9:0]   out_tkeep;
    logic         out_tlast;
    logic         out_tvalid;
    logic         out_tready;

    logic [39:0]  q_in_tdata;
    logic         q_in_tvalid;
    logic         q_in_tlast;
    logic         q_in_tready;
    logic [159:0] q_out_tdata;
    logic [19:0]  q_out_tkeep;
    logic         q_out_tlast;
    logic         q_out_tvalid;

    int tests = 0;
    int fails = 0;
    bit rnd_mode = 0;
    bit ready_force = 1;

    exp_t        exp_q[$];
    logic [39:0] cur[$];
    got4_t       got4[$];

    gearbox_upsizing_nx #(.N_BYTES(5), .RATIO(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready)
    );

    gearbox_upsizing_nx #(.N_BYTES(5), .RATIO(4)) dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .in_tdata(q_in_tdata), .in_tvalid(q_in_tvalid), .in_tlast(q_in_tlast), .in_tready(q_in_tready),
        .out_tdata(q_out_tdata), .out_tkeep(q_out_tkeep), .out_tlast(q_out_tlast),
        .out_tvalid(q_out_tvalid), .out_tready(1'b1)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: collect beats of a group; a full group or tlast yields one word, lane k at bits k*40.
    task automatic model_accept(input logic [39:0] d, input logic l);
        exp_t e;
        cur.push_back(d);
        if (cur.size() == 2 || l) begin
            e.data = '0;
            e.keep = '0;
            foreach (cur[k]) e.data = e.data | (80'(cur[k]) << (k * 40));
            for (int b = 0; b < cur.size() * 5; b++) e.keep[b] = 1'b1;
            e.last = l;
            exp_q.push_back(e);
            cur.delete();
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send(input logic [39:0] d, input logic l, output int waits);
        bit done = 0;
        bit rdy;
        waits = 0;
        in_tdata  = d;
        in_tlast  = l;
        in_tvalid = 1'b1;
        while (!done) begin
            #1;
            rdy = in_tready;
            @(posedge aclk);
            if (rdy) begin
                model_accept(d, l);
                done = 1;
            end
            @(negedge aclk);
            if (!done) begin
                waits++;
                if (waits > 500) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout: beat %0h not accepted after %0d cycles", d, waits);
                    done = 1;
                end
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("drain", 256'(exp_q.size()), 256'd0);
    endtask

    // Output ready driver.
    initial begin
        out_tready = 1'b0;
        forever begin
            @(negedge aclk);
            out_tready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: every cycle with out_tvalid is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn && out_tvalid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_valid: got data %0h with no expected word", out_tdata);
                end else begin
                    check("out_tdata", 256'(out_tdata), 256'(exp_q[0].data));
                    check("out_tkeep", 256'(out_tkeep), 256'(exp_q[0].keep));
                    check("out_tlast", 256'(out_tlast), 256'(exp_q[0].last));
                    if (!out_tready) check("stall_in_tready", 256'(in_tready), 256'd0);
                    else exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn && q_out_tvalid)
                got4.push_back('{data: q_out_tdata, keep: q_out_tkeep, last: q_out_tlast});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1;
        aclk = 0;
        aresetn = 0;
        in_tdata = '0; in_tvalid = 0; in_tlast = 0;
        q_in_tdata = '0; q_in_tvalid = 0; q_in_tlast = 0;

        repeat (2) @(negedge aclk);
        #1;
        check("rst_out_tvalid", 256'(out_tvalid), 256'd0);
        check("rst_out_tdata",  256'(out_tdata),  256'd0);
        check("rst_out_tkeep",  256'(out_tkeep),  256'd0);
        check("rst_out_tlast",  256'(out_tlast),  256'd0);
        check("rst_in_tready",  256'(in_tready),  256'd0);
        @(negedge aclk);
        aresetn = 1;
        #1;
        check("in_tready_after_reset", 256'(in_tready), 256'd1);
        @(negedge aclk);

        // Back-to-back group, no stalls expected.
        send(40'h4142434445, 1'b0, w0);
        send(40'h464748494A, 1'b0, w1);
        check("b2b_no_stall", 256'(w0 + w1), 256'd0);
        wait_drain();

        // Long pause mid-group.
        send(40'h4142434445, 1'b0, w0);
        repeat (16) @(negedge aclk);
        send(40'h464748494A, 1'b0, w1);
        wait_drain();

        // RATIO=4: partial flush on tlast, then a fresh packet from lane 0.
        q_in_tvalid = 1; q_in_tdata = 40'h4141414141; q_in_tlast = 0;
        @(negedge aclk); q_in_tdata = 40'h4242424242;
        @(negedge aclk); q_in_tdata = 40'h4343434343; q_in_tlast = 1;
        @(negedge aclk); q_in_tdata = 40'h4444444444; q_in_tlast = 1;
        @(negedge aclk); q_in_tvalid = 0; q_in_tlast = 0;
        repeat (4) @(negedge aclk);
        check("r4_count", 256'(got4.size()), 256'd2);
        if (got4.size() == 2) begin
            check("r4_w0_data", 256'(got4[0].data), 256'(160'h4343434343_4242424242_4141414141));
            check("r4_w0_keep", 256'(got4[0].keep), 256'(20'h07FFF));
            check("r4_w0_last", 256'(got4[0].last), 256'd1);
            check("r4_w1_data", 256'(got4[1].data), 256'(160'h4444444444));
            check("r4_w1_keep", 256'(got4[1].keep), 256'(20'h0001F));
            check("r4_w1_last", 256'(got4[1].last), 256'd1);
        end

        // Backpressure: hold the first word for ~10 cycles while the next group waits.
        ready_force = 0;
        @(negedge aclk);
        send(40'h1111111111, 1'b0, w0);
        send(40'h2222222222, 1'b0, w1);
        fork
            begin
                repeat (10) @(negedge aclk);
                ready_force = 1;
            end
        join_none
        send(40'h3333333333, 1'b0, w0);
        check("stall_waited", 256'(w0 >= 9), 256'd1);
        send(40'h4444444444, 1'b1, w1);
        wait_drain();

        // Random valid/ready with random tlast.
        rnd_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            logic l;
            while ($urandom_range(0, 1) == 0) @(negedge aclk);
            l = (i == 999) ? 1'b1 : ($urandom_range(0, 3) == 0);
            send(40'($urandom()) ^ (40'($urandom()) << 8), l, w0);
        end
        rnd_mode = 0;
        ready_force = 1;
        wait_drain();

        // Reset mid-group discards the partial accumulator.
        @(negedge aclk);
        send(40'h5A5A5A5A5A, 1'b0, w0);
        aresetn = 0;
        cur.delete();
        #1;
        check("midrst_out_tvalid", 256'(out_tvalid), 256'd0);
        check("midrst_out_tdata",  256'(out_tdata),  256'd0);
        check("midrst_out_tkeep",  256'(out_tkeep),  256'd0);
        check("midrst_in_tready",  256'(in_tready),  256'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        send(40'h4B4C4D4E4F, 1'b0, w0);
        send(40'h5051525354, 1'b0, w1);
        wait_drain();

        repeat (4) @(negedge aclk);
        check("final_partial_empty", 256'(cur.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
